// File: rtl/fs_bus_arbiter_if.sv
// Shared flash/SSRAM bus bundle: two Avalon-MM slave ports plus the pin-level bus.
// Latency: none, wires only.
// Backpressure: the per-port waitrequest signals carried here.
//
// Modports:
//   slave  - the arbiter side (Avalon commands in, read returns out, pins out)
//   master - the system side (Avalon masters and pad logic)
interface fs_bus_arbiter_if #(
  parameter int SR_AW  = 20,
  parameter int FL_AW  = 26,
  parameter int ADDR_W = 27
);
  // SSRAM Avalon port
  logic [SR_AW-1:0]  sr_address;
  logic              sr_read;
  logic              sr_write;
  logic [3:0]        sr_byteenable;
  logic [31:0]       sr_writedata;
  logic [31:0]       sr_readdata;
  logic              sr_readdatavalid;
  logic              sr_waitrequest;
  // Flash Avalon port
  logic [FL_AW-1:0]  fl_address;
  logic              fl_read;
  logic              fl_write;
  logic [15:0]       fl_writedata;
  logic [15:0]       fl_readdata;
  logic              fl_readdatavalid;
  logic              fl_waitrequest;
  // Pin-level shared bus
  logic [ADDR_W-1:0] fs_addr;
  logic [31:0]       fs_dq_out;
  logic              fs_dq_oe;
  logic [31:0]       fs_dq_in;
  logic              ssram_adsc_n;
  logic              ssram_ce_n;
  logic              ssram_oe_n;
  logic              ssram_we_n;
  logic [3:0]        ssram_be_n;
  logic              fl_ce_n;
  logic              fl_oe_n;
  logic              fl_we_n;

  modport slave (
    input  sr_address, sr_read, sr_write, sr_byteenable, sr_writedata,
    output sr_readdata, sr_readdatavalid, sr_waitrequest,
    input  fl_address, fl_read, fl_write, fl_writedata,
    output fl_readdata, fl_readdatavalid, fl_waitrequest,
    output fs_addr, fs_dq_out, fs_dq_oe,
    input  fs_dq_in,
    output ssram_adsc_n, ssram_ce_n, ssram_oe_n, ssram_we_n, ssram_be_n,
    output fl_ce_n, fl_oe_n, fl_we_n
  );

  modport master (
    output sr_address, sr_read, sr_write, sr_byteenable, sr_writedata,
    input  sr_readdata, sr_readdatavalid, sr_waitrequest,
    output fl_address, fl_read, fl_write, fl_writedata,
    input  fl_readdata, fl_readdatavalid, fl_waitrequest,
    input  fs_addr, fs_dq_out, fs_dq_oe,
    output fs_dq_in,
    input  ssram_adsc_n, ssram_ce_n, ssram_oe_n, ssram_we_n, ssram_be_n,
    input  fl_ce_n, fl_oe_n, fl_we_n
  );
endinterface

// File: rtl/fs_bus_arbiter.sv
// Arbiter and timing controller for the shared flash/SSRAM pin bus.
// Latency: SSRAM read accept-to-valid SR_RD_LAT+2; flash read accept-to-valid FL_RD_WAIT+2.
// Backpressure: one transaction in flight; waitrequest drops for one cycle only when the port is granted in IDLE.
//
// Ports: clk_clk (single rising-edge clock), reset_reset_n (async, active low),
//   bus (fs_bus_arbiter_if.slave): SSRAM/flash Avalon ports and the shared pins.
// Optional feature macro FS_SR_PRIORITY_EN: SSRAM wins every tie (flash may starve);
//   when undefined, ties are broken round-robin with SSRAM first after reset.
module fs_bus_arbiter #(
  parameter int SR_AW      = 20,
  parameter int FL_AW      = 26,
  parameter int ADDR_W     = 27,
  parameter int SR_RD_LAT  = 2,
  parameter int FL_RD_WAIT = 8,
  parameter int FL_WR_WAIT = 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  fs_bus_arbiter_if.slave   bus
);

  localparam int CNT_W = $clog2(64);
  localparam logic [CNT_W-1:0] SR_LD    = CNT_W'(SR_RD_LAT - 1);
  localparam logic [CNT_W-1:0] FL_RD_LD = CNT_W'(FL_RD_WAIT - 1);
  localparam logic [CNT_W-1:0] FL_WR_LD = CNT_W'(FL_WR_WAIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SR_ADS,
    ST_SR_WAIT,
    ST_FL_SETUP,
    ST_FL_PULSE,
    ST_FL_HOLD,
    ST_TURN
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_dq_out;
  logic              r_dq_oe;
  logic              r_adsc_n, r_sr_ce_n, r_sr_oe_n, r_sr_we_n;
  logic [3:0]        r_be_n;
  logic              r_fl_ce_n, r_fl_oe_n, r_fl_we_n;
  logic [31:0]       r_sr_rd;
  logic [15:0]       r_fl_rd;
  logic              r_sr_rdv, r_fl_rdv;
`ifndef FS_SR_PRIORITY_EN
  logic              r_last_fl;  // 1 = flash was granted most recently
`endif

  logic              w_sr_req, w_fl_req;
  logic              w_gnt_sr, w_gnt_fl;
  logic              w_sr_acc, w_fl_acc;
  logic              w_turn_after_wr;
  logic [ADDR_W-1:0] w_sr_addr, w_fl_addr;

  assign w_sr_req = bus.sr_read | bus.sr_write;
  assign w_fl_req = bus.fl_read | bus.fl_write;

`ifdef FS_SR_PRIORITY_EN
  assign w_gnt_sr = w_sr_req;
  assign w_gnt_fl = w_fl_req & ~w_sr_req;
`else
  assign w_gnt_sr = w_sr_req & (~w_fl_req | r_last_fl);
  assign w_gnt_fl = w_fl_req & (~w_sr_req | ~r_last_fl);
`endif

  // Gating with the reset pin keeps waitrequest high while reset is held,
  // since the state register already reads IDLE during reset.
  assign w_sr_acc = (r_state == ST_IDLE) & reset_reset_n & w_gnt_sr;
  assign w_fl_acc = (r_state == ST_IDLE) & reset_reset_n & w_gnt_fl;

  // After an SSRAM write, only another pure SSRAM write may follow without a
  // turnaround; anything else pending means the bus direction may change.
  assign w_turn_after_wr = (bus.sr_read & ~bus.sr_write) | w_fl_req;

  assign w_sr_addr = ADDR_W'({bus.sr_address, 2'b00});
  assign w_fl_addr = ADDR_W'({bus.fl_address, 1'b0});

  // Strobes are recomputed every cycle for the state being entered, so each
  // state only lists the strobes it holds active.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_wr      <= 1'b0;
      r_addr    <= '0;
      r_dq_out  <= '0;
      r_dq_oe   <= 1'b0;
      r_adsc_n  <= 1'b1;
      r_sr_ce_n <= 1'b1;
      r_sr_oe_n <= 1'b1;
      r_sr_we_n <= 1'b1;
      r_be_n    <= 4'hF;
      r_fl_ce_n <= 1'b1;
      r_fl_oe_n <= 1'b1;
      r_fl_we_n <= 1'b1;
      r_sr_rd   <= '0;
      r_fl_rd   <= '0;
      r_sr_rdv  <= 1'b0;
      r_fl_rdv  <= 1'b0;
`ifndef FS_SR_PRIORITY_EN
      r_last_fl <= 1'b1;
`endif
    end else begin
      r_adsc_n  <= 1'b1;
      r_sr_ce_n <= 1'b1;
      r_sr_oe_n <= 1'b1;
      r_sr_we_n <= 1'b1;
      r_be_n    <= 4'hF;
      r_fl_ce_n <= 1'b1;
      r_fl_oe_n <= 1'b1;
      r_fl_we_n <= 1'b1;
      r_dq_oe   <= 1'b0;
      r_sr_rdv  <= 1'b0;
      r_fl_rdv  <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_sr_acc) begin
            r_state   <= ST_SR_ADS;
            r_wr      <= bus.sr_write;
            r_addr    <= w_sr_addr;
            r_adsc_n  <= 1'b0;
            r_sr_ce_n <= 1'b0;
            if (bus.sr_write) begin
              r_sr_we_n <= 1'b0;
              r_be_n    <= ~bus.sr_byteenable;
              r_dq_oe   <= 1'b1;
              r_dq_out  <= bus.sr_writedata;
            end else begin
              r_be_n    <= 4'h0;
            end
`ifndef FS_SR_PRIORITY_EN
            r_last_fl <= 1'b0;
`endif
          end else if (w_fl_acc) begin
            r_state   <= ST_FL_SETUP;
            r_wr      <= bus.fl_write;
            r_addr    <= w_fl_addr;
            r_fl_ce_n <= 1'b0;
            if (bus.fl_write) begin
              r_dq_oe  <= 1'b1;
              r_dq_out <= {16'h0000, bus.fl_writedata};
            end
`ifndef FS_SR_PRIORITY_EN
            r_last_fl <= 1'b1;
`endif
          end
        end

        ST_SR_ADS: begin
          if (r_wr) begin
            r_state <= w_turn_after_wr ? ST_TURN : ST_IDLE;
          end else begin
            r_state   <= ST_SR_WAIT;
            r_cnt     <= SR_LD;
            r_sr_ce_n <= 1'b0;
            r_sr_oe_n <= 1'b0;
            r_be_n    <= 4'h0;
          end
        end

        ST_SR_WAIT: begin
          if (r_cnt == '0) begin
            r_sr_rd  <= bus.fs_dq_in;
            r_sr_rdv <= 1'b1;
            r_state  <= ST_TURN;
          end else begin
            r_cnt     <= r_cnt - 1'b1;
            r_sr_ce_n <= 1'b0;
            r_sr_oe_n <= 1'b0;
            r_be_n    <= 4'h0;
          end
        end

        ST_FL_SETUP: begin
          r_state   <= ST_FL_PULSE;
          r_cnt     <= r_wr ? FL_WR_LD : FL_RD_LD;
          r_fl_ce_n <= 1'b0;
          r_fl_oe_n <= r_wr;
          r_fl_we_n <= ~r_wr;
          r_dq_oe   <= r_wr;
        end

        ST_FL_PULSE: begin
          r_fl_ce_n <= 1'b0;
          r_dq_oe   <= r_wr;   // write data stays driven into the hold cycle
          if (r_cnt == '0) begin
            r_state <= ST_FL_HOLD;
            if (!r_wr) begin
              r_fl_rd  <= bus.fs_dq_in[15:0];
              r_fl_rdv <= 1'b1;
            end
          end else begin
            r_cnt     <= r_cnt - 1'b1;
            r_fl_oe_n <= r_wr;
            r_fl_we_n <= ~r_wr;
          end
        end

        ST_FL_HOLD: r_state <= ST_TURN;

        ST_TURN: r_state <= ST_IDLE;

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.sr_waitrequest   = ~w_sr_acc;
  assign bus.fl_waitrequest   = ~w_fl_acc;
  assign bus.sr_readdata      = r_sr_rd;
  assign bus.sr_readdatavalid = r_sr_rdv;
  assign bus.fl_readdata      = r_fl_rd;
  assign bus.fl_readdatavalid = r_fl_rdv;
  assign bus.fs_addr          = r_addr;
  assign bus.fs_dq_out        = r_dq_out;
  assign bus.fs_dq_oe         = r_dq_oe;
  assign bus.ssram_adsc_n     = r_adsc_n;
  assign bus.ssram_ce_n       = r_sr_ce_n;
  assign bus.ssram_oe_n       = r_sr_oe_n;
  assign bus.ssram_we_n       = r_sr_we_n;
  assign bus.ssram_be_n       = r_be_n;
  assign bus.fl_ce_n          = r_fl_ce_n;
  assign bus.fl_oe_n          = r_fl_oe_n;
  assign bus.fl_we_n          = r_fl_we_n;

endmodule
